regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file; successor to the single-cycle core's 2-read/1-write file.
- Adds configurable width/depth/read-port count, architectural x0 hardwired to zero, and a sequential bulk-clear engine with busy/done handshake.
- Sits in the decode stage: read ports feed operand muxes, the write port is driven from writeback.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, >= 2.
- NREAD, 2, number of independent combinational read ports, 1..4.
- AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- raddr  in  NREAD*AW  packed read addresses; port k = bits [k*AW +: AW].
- rdata  out  NREAD*XLEN  packed read data; port k = bits [k*XLEN +: XLEN].
- clr_req  in  1  request bulk clear of all registers; sampled when idle.
- clr_busy  out  1  high while a clear is in progress.
- clr_done  out  1  one-cycle pulse on the last clear cycle.

Behaviour:
- Reset (reset=0, async): all registers = 0, FSM = IDLE, clear counter = 0, clr_busy = 0, clr_done = 0. rdata forced to 0 while reset=0.
- Reads: combinational, zero latency. rdata[k] = reg[raddr[k]]; raddr[k]==0 always returns 0.
- Write: on the rising clk edge, if we=1, waddr!=0 and FSM=IDLE, reg[waddr] <= wdata. Writes to address 0 are discarded; reg[0] is never written.
- FSM states:
  - IDLE: clr_busy=0. If clr_req=1, go to CLEAR with counter <= 1.
  - CLEAR: clr_busy=1. Each cycle, reg[counter] <= 0 and counter increments. When counter == NREGS-1, assert clr_done for that cycle and return to IDLE.
  - Clear duration: NREGS-1 cycles after the accepting edge.
- Writes during CLEAR (we=1) are dropped, with no error flag. Writeback must stall on clr_busy.
- clr_req during CLEAR is ignored and does not restart the clear.
- clr_req and we on the same cycle in IDLE: the write commits at that edge, and the clear then zeroes it.
- Reads during CLEAR return current array contents (a mix of cleared and uncleared registers).
- Reset asserted mid-clear: immediate full zero, return to IDLE, no clr_done pulse.
- Counter width: AW bits. Wrap-around cannot occur because termination is at NREGS-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a write-to-read bypass. If we=1, FSM=IDLE, waddr!=0 and raddr[k]==waddr, then rdata[k]=wdata in the same cycle, before the edge (write-first). x0 still reads 0.
- Not defined: rdata[k] shows the pre-write value until after the edge (read-old).

Decomposition:
- Package regfile_pkg holds:
  - default XLEN and NREGS constants;
  - the FSM state typedef (IDLE, CLEAR);
  - the ZERO_REG address constant (0).
- One sub-module, regfile_clear_fsm, owns the state register, counter, clr_busy and clr_done. It exports a clear-write enable and the clear address to the array.

Test Plan:
- Reset: pulse reset low mid-cycle (async), with random prior contents -> all rdata = 0 immediately; after release, reads of x1..x31 = 0.
- Basic write: we=1, waddr=5, wdata=0xDEADBEEF -> after the edge, raddr0=5 gives 0xDEADBEEF; raddr1=0 gives 0.
- x0 protection: we=1, waddr=0, wdata=0xFFFFFFFF -> raddr=0 reads 0 forever.
- Bypass: same-cycle we=1, waddr=7, wdata=0x1234, raddr0=7 -> rdata0=0x1234 before the edge with REGFILE_BYPASS_EN defined; the old value (0) without it.
- Clear: fill x1..x31 with its index, then pulse clr_req -> clr_busy high for 31 cycles, clr_done pulses on the 31st, then all reads = 0. A write of x3=0xAA issued mid-clear is dropped (x3 reads 0).
- Reset mid-clear: reset low at clear cycle 10 -> clr_busy=0 immediately, no clr_done, all rdata = 0; a subsequent clr_req works normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-read-port register file:
//   - default data width and register count,
//   - the bulk-clear FSM state type,
//   - the architectural zero-register address.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // x0 is hardwired to zero: never written, always reads 0.
    localparam int ZERO_REG  = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clear_fsm
// Sequential bulk-clear engine. After a request accepted in IDLE it walks
// x1..x(NREGS-1), one register per cycle, and tells the array which register
// to zero. x0 is skipped because it is never written.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   clr_req   in   clear request, only sampled in IDLE
//   clr_busy  out  high while the clear walk is in progress
//   clr_done  out  one-cycle pulse on the last clear cycle
//   clr_we    out  array zero-write enable for this cycle
//   clr_addr  out  register to zero at the end of this cycle
//   idle      out  FSM is in IDLE (normal writes allowed)
// -----------------------------------------------------------------------------
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          idle
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples its pre-edge value; blocking here would create ordering races.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        idle     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                idle = 1'b1;
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = FIRST_IDX;
                end
            end
            ST_CLEAR: begin
                clr_busy = 1'b1;
                clr_we   = 1'b1;
                // Terminating at NREGS-1 means the AW-bit counter never wraps.
                if (cnt_q == LAST_IDX) begin
                    clr_done = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + FIRST_IDX;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule : regfile_clear_fsm

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised integer register file with NREAD combinational read ports,
// one write port, x0 hardwired to zero and a sequential bulk-clear engine.
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to
// matching read ports (write-first). Without it, reads show the old value
// until after the write edge (read-old).
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset (clears array, forces rdata=0)
//   we        in   write enable (ignored while a clear is running)
//   waddr     in   write address [AW]
//   wdata     in   write data [XLEN]
//   raddr     in   packed read addresses, port k = [k*AW +: AW]
//   rdata     out  packed read data, port k = [k*XLEN +: XLEN]
//   clr_req   in   bulk-clear request, sampled when idle
//   clr_busy  out  clear in progress (writeback must stall)
//   clr_done  out  one-cycle pulse on the last clear cycle
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            fsm_idle;
    logic            wr_en;

    regfile_clear_fsm #(
        .NREGS (NREGS)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .idle     (fsm_idle)
    );

    // Writes are dropped silently while clearing and whenever they target x0.
    assign wr_en = we && fsm_idle && (waddr != ZERO_ADDR);

    // Clear writes and normal writes are mutually exclusive (wr_en needs IDLE,
    // clr_we needs CLEAR), so their order here does not matter.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (clr_we) begin
            mem_d[clr_addr] = '0;
        end
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: the array is reset on purpose: reset must leave every architectural
    // register at zero, which rules out a reset-less RAM macro here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational read ports. Gating with reset makes rdata read zero as
    // soon as reset asserts, without waiting for the array flops to settle.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NREAD; k++) begin
            logic [AW-1:0] ra;
            ra = raddr[k*AW +: AW];
            if (reset && (ra != ZERO_ADDR)) begin
                rdata[k*XLEN +: XLEN] = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
                // wr_en already excludes x0, so x0 still reads zero.
                if (wr_en && (ra == waddr)) begin
                    rdata[k*XLEN +: XLEN] = wdata;
                end
`endif
            end
        end
    end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Randomised scoreboard bench for regfile_mp (XLEN=32, NREGS=32, NREAD=3).
// Stimulus pushes the expected outputs of each cycle into a queue; a monitor
// pops and compares them at the falling edge, when the DUT outputs are stable.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 3;
    localparam int AW    = 5;

    logic                  clk;
    logic                  reset;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;
    logic [NREAD*AW-1:0]   raddr;
    logic [NREAD*XLEN-1:0] rdata;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  clr_done;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef enum int { K_RDATA, K_BUSY, K_DONE } kind_e;
    typedef struct {
        string           name;
        kind_e           kind;
        int              port;
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [XLEN-1:0] got,
                         input logic [XLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t            e;
            logic [XLEN-1:0] got;
            e = exp_q.pop_front();
            case (e.kind)
                K_RDATA: got = rdata[e.port*XLEN +: XLEN];
                K_BUSY:  got = {{(XLEN-1){1'b0}}, clr_busy};
                default: got = {{(XLEN-1){1'b0}}, clr_done};
            endcase
            check(e.name, got, e.exp);
        end
    end

    // ---------------- reference model ----------------
    // Architectural contents plus "how many clear cycles remain". While a
    // clear runs, the register being zeroed this cycle is NREGS - clr_left.
    logic [XLEN-1:0] model [NREGS];
    int              clr_left = 0;

    function automatic logic [XLEN-1:0] model_read(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && clr_left == 0 && int'(waddr) == a) return wdata;
`endif
        return model[a];
    endfunction

    task automatic expect_cycle(input string tag);
        exp_t e;
        for (int k = 0; k < NREAD; k++) begin
            e.name = $sformatf("%s.rdata%0d[x%0d]", tag, k, raddr[k*AW +: AW]);
            e.kind = K_RDATA;
            e.port = k;
            e.exp  = reset ? model_read(int'(raddr[k*AW +: AW])) : '0;
            exp_q.push_back(e);
        end
        e.name = {tag, ".clr_busy"};
        e.kind = K_BUSY;
        e.port = 0;
        e.exp  = (reset && clr_left > 0) ? 1 : 0;
        exp_q.push_back(e);
        e.name = {tag, ".clr_done"};
        e.kind = K_DONE;
        e.exp  = (reset && clr_left == 1) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // Advance one clock edge, applying the architectural effect to the model.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) model[i] = '0;
            clr_left = 0;
        end else if (clr_left > 0) begin
            model[NREGS - clr_left] = '0;
            clr_left--;
        end else begin
            if (we && waddr != 0) model[waddr] = wdata;
            if (clr_req) clr_left = NREGS - 1;
        end
        #1;
    endtask

    task automatic cyc(input string tag, input logic we_i, input int wa,
                       input logic [XLEN-1:0] wd, input logic clr_i,
                       input int r0, input int r1, input int r2);
        we      = we_i;
        waddr   = AW'(wa);
        wdata   = wd;
        clr_req = clr_i;
        raddr   = {AW'(r2), AW'(r1), AW'(r0)};
        expect_cycle(tag);
        tick();
    endtask

    function automatic int ra();
        return int'($urandom_range(0, NREGS - 1));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr   = '0;
        clr_req = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        // Power-up reset.
        @(posedge clk); #1;
        expect_cycle("por");
        tick();
        reset = 1'b1;

        // All registers read zero after release.
        for (int i = 1; i < NREGS; i += 3)
            cyc("post_rst", 0, 0, '0, 0, i, i + 1, (i + 2) % NREGS);

        // Basic write, then read back alongside x0.
        cyc("wr5", 1, 5, 32'hDEADBEEF, 0, 5, 0, 1);
        cyc("rd5", 0, 0, '0, 0, 5, 0, 5);

        // x0 protection.
        cyc("wr0", 1, 0, 32'hFFFFFFFF, 0, 0, 0, 5);
        cyc("rd0", 0, 0, '0, 0, 0, 0, 0);

        // Same-cycle write/read of x7: bypass or read-old per build.
        cyc("byp7", 1, 7, 32'h00001234, 0, 7, 0, 7);
        cyc("rd7", 0, 0, '0, 0, 7, 5, 0);

        // Random traffic with occasional clears and read/write collisions.
        for (int n = 0; n < 300; n++) begin
            int wa;
            wa = ra();
            cyc("rand", ($urandom_range(0, 2) != 0), wa, $urandom,
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 3) == 0) ? wa : ra(), ra(), ra());
        end
        // Let any clear started above finish.
        for (int n = 0; n < NREGS && clr_left > 0; n++)
            cyc("drain", 0, 0, '0, 0, ra(), ra(), ra());

        // Async reset mid-cycle with random contents.
        reset = 1'b0;
        expect_cycle("async_rst");
        tick();
        reset = 1'b1;
        for (int i = 1; i < NREGS; i += 3)
            cyc("after_rst", 0, 0, '0, 0, i, i + 1, (i + 2) % NREGS);

        // Fill x_i = i, then a full clear with a dropped write and a re-request.
        for (int i = 1; i < NREGS; i++)
            cyc("fill", 1, i, XLEN'(i), 0, i, ra(), 0);
        cyc("clr_go", 0, 0, '0, 1, 3, 30, 31);
        for (int c = 1; c < NREGS; c++) begin
            if (c == 15)     cyc("clr_wr3", 1, 3, 32'hAA, 0, 3, 16, 31);
            else if (c == 5) cyc("clr_rereq", 0, 0, '0, 1, ra(), ra(), ra());
            else             cyc("clearing", 0, 0, '0, 0, c, ra(), 3);
        end
        for (int i = 1; i < NREGS; i += 3)
            cyc("cleared", 0, 0, '0, 0, i, i + 1, (i + 2) % NREGS);

        // Write and clear request in the same idle cycle.
        cyc("wr_and_clr", 1, 9, 32'h55, 1, 9, 0, 9);
        for (int c = 1; c < NREGS; c++)
            cyc("clr2", 0, 0, '0, 0, 9, ra(), ra());
        cyc("rd9", 0, 0, '0, 0, 9, 0, 9);

        // Reset asserted during clear cycle 10.
        for (int i = 1; i < NREGS; i++)
            cyc("refill", 1, i, $urandom, 0, ra(), ra(), ra());
        cyc("clr3_go", 0, 0, '0, 1, ra(), ra(), ra());
        for (int c = 1; c < 10; c++)
            cyc("clr3", 0, 0, '0, 0, ra(), ra(), ra());
        reset = 1'b0;
        expect_cycle("rst_mid_clr");
        tick();
        reset = 1'b1;
        for (int n = 0; n < 3; n++)
            cyc("idle_after", 0, 0, '0, 0, ra(), ra(), ra());

        // A fresh clear works normally afterwards.
        cyc("wr12", 1, 12, 32'hCAFEF00D, 0, 12, 0, 1);
        cyc("clr4_go", 0, 0, '0, 1, 12, ra(), ra());
        for (int c = 1; c < NREGS; c++)
            cyc("clr4", 0, 0, '0, 0, 12, c, ra());
        cyc("rd12", 0, 0, '0, 0, 12, 0, 31);

        @(negedge clk); #1;
        check("queue_drained", XLEN'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp
